// File: rtl/conv_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | conv_pkg : shared sizing helpers and FSM state encoding for conv2d_engine  |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Port/counter width that never collapses to zero bits.
  function automatic int wbits(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  function automatic int out_rows(input int rows, input int k, input int s);
    return (rows - k) / s + 1;
  endfunction

  function automatic int out_cols(input int cols, input int k, input int s);
    return (cols - k) / s + 1;
  endfunction

  function automatic int n_terms(input int ch, input int k);
    return ch * k * k;
  endfunction

  function automatic int acc_w(input int pw, input int kw, input int n);
    return pw + kw + 1 + clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | conv_mac : unsigned-pixel x signed-coefficient MAC, saturate + ReLU       |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module conv_mac
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int KER_W = 8,
  parameter int OUT_W = 22,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_first,
  input  logic             i_last,
  input  logic             i_relu,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [KER_W-1:0] i_ker,
  output logic [OUT_W-1:0] o_data
);

  localparam int PROD_W = PIX_W + KER_W + 1;

  logic signed [PROD_W-1:0] w_pix_s;
  logic signed [PROD_W-1:0] w_ker_s;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic        [OUT_W-1:0]  w_sat;
  logic        [OUT_W-1:0]  w_res;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [OUT_W-1:0]  r_out;

  assign w_pix_s    = PROD_W'($signed({1'b0, i_pix}));
  assign w_ker_s    = PROD_W'($signed(i_ker));
  assign w_prod     = w_pix_s * w_ker_s;
  assign w_prod_ext = ACC_W'(w_prod);
  // First term of a window replaces the stale sum instead of adding to it.
  assign w_sum      = (i_first ? '0 : r_acc) + w_prod_ext;

  generate
    if (OUT_W < ACC_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
      localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;
      always_comb begin
        if (w_sum > C_MAX)      w_sat = C_MAX[OUT_W-1:0];
        else if (w_sum < C_MIN) w_sat = C_MIN[OUT_W-1:0];
        else                    w_sat = w_sum[OUT_W-1:0];
      end
    end else begin : g_wide
      assign w_sat = OUT_W'(w_sum);
    end
  endgenerate

  assign w_res  = (i_relu && w_sat[OUT_W-1]) ? '0 : w_sat;
  assign o_data = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
      if (i_last) r_out <= w_res;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_engine.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | conv2d_engine : sequential multi-channel 2D convolution, one MAC, FSM      |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int IMG_ROWS = 128,
  parameter int IMG_COLS = 128,
  parameter int CHANNELS = 3,
  parameter int K        = 8,
  parameter int STRIDE   = 4,
  parameter int PIX_W    = 8,
  parameter int KER_W    = 8,
  parameter int OUT_W    = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic relu_en,
  output logic busy,
  output logic done,
  output logic [wbits(CHANNELS*IMG_ROWS*IMG_COLS)-1:0] img_addr,
  input  logic [PIX_W-1:0] img_data,
  output logic [wbits(CHANNELS*K*K)-1:0] ker_addr,
  input  logic [KER_W-1:0] ker_data,
  output logic out_valid,
  output logic [wbits(out_rows(IMG_ROWS,K,STRIDE)*out_cols(IMG_COLS,K,STRIDE))-1:0] out_addr,
  output logic [OUT_W-1:0] out_data
);

  localparam int OUT_R = out_rows(IMG_ROWS, K, STRIDE);
  localparam int OUT_C = out_cols(IMG_COLS, K, STRIDE);
  localparam int N     = n_terms(CHANNELS, K);
  localparam int ACC_W = acc_w(PIX_W, KER_W, N);
  localparam int IA_W  = wbits(CHANNELS * IMG_ROWS * IMG_COLS);
  localparam int KA_W  = wbits(N);
  localparam int OA_W  = wbits(OUT_R * OUT_C);
  localparam int KCW   = wbits(K);
  localparam int CHW   = wbits(CHANNELS);
  localparam int ORW   = wbits(OUT_R);
  localparam int OCW   = wbits(OUT_C);
  localparam int C_PLANE = IMG_ROWS * IMG_COLS;
  localparam int C_KK    = K * K;

  localparam logic [KCW-1:0] C_K_LAST  = KCW'(K - 1);
  localparam logic [CHW-1:0] C_CH_LAST = CHW'(CHANNELS - 1);
  localparam logic [ORW-1:0] C_OR_LAST = ORW'(OUT_R - 1);
  localparam logic [OCW-1:0] C_OC_LAST = OCW'(OUT_C - 1);

  state_t          r_state;
  logic            r_busy, r_done, r_out_valid, r_relu;
  logic            r_acc_en, r_first, r_last;
  logic [KCW-1:0]  r_kc, r_kr, w_kc, w_kr;
  logic [CHW-1:0]  r_ch, w_ch;
  logic [ORW-1:0]  r_orow, w_orow;
  logic [OCW-1:0]  r_ocol, w_ocol;
  logic [IA_W-1:0] r_img_addr;
  logic [KA_W-1:0] r_ker_addr;
  logic [OA_W-1:0] r_out_addr;
  logic            w_load, w_first_term, w_last_term, w_last_win;

  assign w_first_term = (r_ch == '0) && (r_kr == '0) && (r_kc == '0);
  assign w_last_term  = (r_ch == C_CH_LAST) && (r_kr == C_K_LAST) && (r_kc == C_K_LAST);
  assign w_last_win   = (r_orow == C_OR_LAST) && (r_ocol == C_OC_LAST);

  // Next counter values; w_load marks edges where a new address pair is driven.
  always_comb begin
    w_kc   = r_kc;
    w_kr   = r_kr;
    w_ch   = r_ch;
    w_orow = r_orow;
    w_ocol = r_ocol;
    w_load = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_kc = '0; w_kr = '0; w_ch = '0; w_orow = '0; w_ocol = '0;
        w_load = 1'b1;
      end
      ISSUE: if (!w_last_term) begin
        w_load = 1'b1;
        if (r_kc != C_K_LAST) w_kc = r_kc + KCW'(1);
        else begin
          w_kc = '0;
          if (r_kr != C_K_LAST) w_kr = r_kr + KCW'(1);
          else begin
            w_kr = '0;
            w_ch = r_ch + CHW'(1);
          end
        end
      end
      WRITE: if (!w_last_win) begin
        w_load = 1'b1;
        w_kc = '0; w_kr = '0; w_ch = '0;
        if (r_ocol != C_OC_LAST) w_ocol = r_ocol + OCW'(1);
        else begin
          w_ocol = '0;
          w_orow = r_orow + ORW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_relu      <= 1'b0;
      r_acc_en    <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_kc        <= '0;
      r_kr        <= '0;
      r_ch        <= '0;
      r_orow      <= '0;
      r_ocol      <= '0;
      r_img_addr  <= '0;
      r_ker_addr  <= '0;
      r_out_addr  <= '0;
    end else begin
      r_kc   <= w_kc;
      r_kr   <= w_kr;
      r_ch   <= w_ch;
      r_orow <= w_orow;
      r_ocol <= w_ocol;
      if (w_load) begin
        r_img_addr <= IA_W'(32'(w_ch) * 32'(C_PLANE)
                          + (32'(w_orow) * 32'(STRIDE) + 32'(w_kr)) * 32'(IMG_COLS)
                          + 32'(w_ocol) * 32'(STRIDE) + 32'(w_kc));
        r_ker_addr <= KA_W'(32'(w_ch) * 32'(C_KK) + 32'(w_kr) * 32'(K) + 32'(w_kc));
      end
      // Read data lags the address by one cycle, so MAC controls are delayed to match.
      r_acc_en    <= (r_state == ISSUE);
      r_first     <= (r_state == ISSUE) && w_first_term;
      r_last      <= (r_state == ISSUE) && w_last_term;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= ISSUE;
          r_busy  <= 1'b1;
          r_relu  <= relu_en;
        end
        ISSUE: if (w_last_term) r_state <= DRAIN;
        DRAIN: begin
          r_state     <= WRITE;
          r_out_valid <= 1'b1;
          r_out_addr  <= OA_W'(32'(r_orow) * 32'(OUT_C) + 32'(r_ocol));
        end
        WRITE: begin
          if (w_last_win) begin
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ISSUE;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  conv_mac #(
    .PIX_W(PIX_W),
    .KER_W(KER_W),
    .OUT_W(OUT_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_acc_en),
    .i_first(r_first),
    .i_last (r_last),
    .i_relu (r_relu),
    .i_pix  (img_data),
    .i_ker  (ker_data),
    .o_data (out_data)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_valid = r_out_valid;
  assign img_addr  = r_img_addr;
  assign ker_addr  = r_ker_addr;
  assign out_addr  = r_out_addr;

endmodule
`default_nettype wire
